// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a-b using one full-subtractor cell, LSB first.
// Optional SERIAL_SUB_CMP_EN adds a_lt_b / a_eq_b compare flags.
module serial_sub_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_CMP_EN
    ,
    output logic             a_lt_b,
    output logic             a_eq_b
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    // Holds the WIDTH-1 bits produced so far; the last bit goes
    // straight into the result register.
    logic [WIDTH-2:0] diff_sr_q;
    logic [WIDTH-1:0] diff_sr_d;
    logic             borrow_q;
    logic             borrow_d;
    logic             diff_bit;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_out_q;
    logic             accept;
    logic             last;

`ifdef SERIAL_SUB_CMP_EN
    logic             nz_q;
    logic             a_lt_b_q;
    logic             a_eq_b_q;
`else
    // Compare flags are not built in this configuration.
`endif

    // One full-subtractor cell fed from the operand LSBs and borrow flop.
    always_comb begin
        diff_bit  = a_sr_q[0] ^ b_sr_q[0] ^ borrow_q;
        borrow_d  = (~a_sr_q[0] & (b_sr_q[0] ^ borrow_q))
                  | (b_sr_q[0] & borrow_q);
        diff_sr_d = {diff_bit, diff_sr_q};
        cnt_d     = cnt_q + CNT_W'(1);
        last      = (cnt_q == LAST);
        accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            diff_sr_q    <= '0;
            borrow_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_CMP_EN
            nz_q         <= 1'b0;
            a_lt_b_q     <= 1'b0;
            a_eq_b_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                state_q   <= S_RUN;
                cnt_q     <= '0;
                a_sr_q    <= a;
                b_sr_q    <= b;
                diff_sr_q <= '0;
                borrow_q  <= 1'b0;
                busy_q    <= 1'b1;
`ifdef SERIAL_SUB_CMP_EN
                nz_q      <= 1'b0;
`endif
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_RUN: begin
                        a_sr_q    <= {1'b0, a_sr_q[WIDTH-1:1]};
                        b_sr_q    <= {1'b0, b_sr_q[WIDTH-1:1]};
                        diff_sr_q <= diff_sr_d[WIDTH-1:1];
                        borrow_q  <= borrow_d;
`ifdef SERIAL_SUB_CMP_EN
                        nz_q      <= nz_q | diff_bit;
`endif
                        if (last) begin
                            state_q      <= S_DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            diff_q       <= diff_sr_d;
                            borrow_out_q <= borrow_d;
`ifdef SERIAL_SUB_CMP_EN
                            a_lt_b_q     <= borrow_d;
                            a_eq_b_q     <= ~(nz_q | diff_bit);
`endif
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_CMP_EN
    assign a_lt_b     = a_lt_b_q;
    assign a_eq_b     = a_eq_b_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed + random stimulus against a cycle-level
// arithmetic model of the serial subtractor handshake.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_CMP_EN
    logic         a_lt_b;
    logic         a_eq_b;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a_s),
        .b          (b_s),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_CMP_EN
        ,
        .a_lt_b     (a_lt_b),
        .a_eq_b     (a_eq_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: ph = 0 idle, 1..W = processing cycle index, W+1 = done cycle.
    int           ph = 0;
    logic [W-1:0] p_diff;
    logic         p_bor;
    logic [W-1:0] m_diff = '0;
    logic         m_bor = 1'b0;
    logic         m_eq = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ph     = 0;
            m_diff = '0;
            m_bor  = 1'b0;
            m_eq   = 1'b0;
        end else if ((ph == 0 || ph == W + 1) && start) begin
            ph     = 1;
            p_diff = a_s - b_s;
            p_bor  = (a_s < b_s);
        end else if (ph >= 1 && ph < W) begin
            ph++;
        end else if (ph == W) begin
            ph     = W + 1;
            m_diff = p_diff;
            m_bor  = p_bor;
            m_eq   = (p_diff == '0);
        end else begin
            ph = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", busy, (ph >= 1 && ph <= W));
            chk("m_done", done, (ph == W + 1));
            chk("m_diff", diff, m_diff);
            chk("m_borrow", borrow_out, m_bor);
`ifdef SERIAL_SUB_CMP_EN
            chk("m_lt", a_lt_b, m_bor);
            chk("m_eq", a_eq_b, m_eq);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int lim, output int n, output int nb);
        bit ok;
        ok = 0;
        n  = 0;
        nb = 0;
        while (!ok && n < lim) begin
            @(negedge clk);
            n++;
            if (done) ok = 1;
            else if (busy) nb++;
        end
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] ed,
                         input logic eb, input logic eq);
        int n, nb;
        start = 1'b1;
        a_s   = av;
        b_s   = bv;
        cyc();
        start = 1'b0;
        a_s   = W'($urandom);
        b_s   = W'($urandom);
        wait_done(20, n, nb);
        chk({nm, "_lat"}, n, W + 1);
        chk({nm, "_busycnt"}, nb, W);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_bor"}, borrow_out, eb);
`ifdef SERIAL_SUB_CMP_EN
        chk({nm, "_lt"}, a_lt_b, eb);
        chk({nm, "_eq"}, a_eq_b, eq);
`else
        if (eq && ed != '0) $display("note: inconsistent eq for %s", nm);
`endif
        cyc();
    endtask

    initial begin
        int n, nb;
        rst   = 1'b1;
        start = 1'b0;
        a_s   = '0;
        b_s   = '0;
        cyc();
        chk_en = 1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bor", borrow_out, 0);
        cyc();

        do_op("t200_55", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
        do_op("t5_10", 8'd5, 8'd10, 8'hFB, 1'b1, 1'b0);
        do_op("t3c_3c", 8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1);

        // Start while busy is ignored.
        start = 1'b1;
        a_s   = 8'h00;
        b_s   = 8'h01;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        start = 1'b1;
        a_s   = 8'd9;
        b_s   = 8'd1;
        cyc();
        start = 1'b0;
        wait_done(20, n, nb);
        chk("ign_lat", n, 5);
        chk("ign_diff", diff, 8'hFF);
        chk("ign_bor", borrow_out, 1);
        cyc();

        // Back-to-back with start held high.
        start = 1'b1;
        a_s   = 8'hFF;
        b_s   = 8'h01;
        cyc();
        wait_done(20, n, nb);
        chk("b2b1_lat", n, W + 1);
        chk("b2b1_diff", diff, 8'hFE);
        chk("b2b1_bor", borrow_out, 0);
        a_s = 8'h10;
        b_s = 8'h20;
        cyc();
        start = 1'b0;
        for (int i = 1; i <= W + 1; i++) begin
            @(negedge clk);
            if (i <= W) begin
                chk("b2b_hold_diff", diff, 8'hFE);
                chk("b2b_hold_busy", busy, 1);
            end else begin
                chk("b2b2_done", done, 1);
                chk("b2b2_diff", diff, 8'hF0);
                chk("b2b2_bor", borrow_out, 1);
            end
        end
        cyc();

        // Reset in the middle of an operation.
        start = 1'b1;
        a_s   = 8'd100;
        b_s   = 8'd1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_diff", diff, 0);
        chk("mrst_bor", borrow_out, 0);
        nb = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) nb++;
        end
        chk("mrst_nodone", nb, 0);
        cyc();
        do_op("after_rst", 8'd100, 8'd1, 8'd99, 1'b0, 1'b0);

        // Random traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 2) == 0);
            a_s   = W'($urandom);
            b_s   = ($urandom_range(0, 7) == 0) ? a_s : W'($urandom);
            cyc();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (W + 4) cyc();
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
